pd_predecode: RTL
=================

# pd_predecode

Predecode stage between instruction fetch and the `pd`→`id` pipeline register. It classifies the fetched instruction's branch type, predicts direction with a gshare PHT, and predicts register-jump targets with a tagged BTB. It emits the `pd_*` bundle consumed by the pd/id register and a one-cycle fetch redirect. It holds the speculative and architectural global history, the PHT and the BTB, and updates them from EX-stage resolution.

## Interface
- `GHR_LEN`, default `` `GHR_LEN `` (8): history bits; PHT depth is 2^GHR_LEN.
- `BTB_LEN`, default `` `BTB_LEN `` (6): BTB index bits; BTB depth is 2^BTB_LEN.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `stall` in 1: hold stage; no state advances.
- `refresh` in 1: exception flush.
- `if_valid` in 1: fetched instruction present.
- `if_addr_error`, `if_pc`[31:0], `if_inst`[31:0] in: fetch bundle.
- `ex_gshare_wen` in 1, `ex_gshare_windex` in GHR_LEN, `ex_taken` in 1: conditional-branch resolution.
- `ex_btb_wen` in 1, `ex_btb_windex` in BTB_LEN, `ex_btb_wpc` in 32, `ex_btb_wtarget` in 32: resolved JR/JALR.
- `ex_bp_fail` in 1: misprediction at EX.
- `pd_addr_error`, `pd_pc`, `pd_pc_8`, `pd_inst`, `pd_bd`, `pd_branch`, `pd_b`, `pd_j_dir`, `pd_j_r`, `pd_b_rs_ren`, `pd_b_rt_ren` out: predecode bundle.
- `pd_btb_wen`/`windex`/`wtarget`, `pd_gshare_wen`/`windex`, `pd_bp_take` out: predictor tags carried down the pipe.
- `pd_op_bltz`/`bgez`/`beq`/`bne`/`blez`/`bgtz` out: condition one-hots.
- `pd_redirect` out 1, `pd_redirect_pc` out 32: fetch redirect.

## Operation
- Valid instruction: `v = if_valid & ~if_addr_error`. When `v=0`, every branch and op flag, every wen, `pd_bp_take` and `pd_redirect` are 0.
- Decode:
  - `j_dir`: opcode 000010 or 000011.
  - `j_r`: opcode 000000 with funct 001000 or 001001.
  - `b`: BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111, or REGIMM 000001 with rt ∈ {00000, 10000} → bltz, rt ∈ {00001, 10001} → bgez.
  - `pd_branch = b|j_dir|j_r`. `pd_b_rs_ren = b|j_r`. `pd_b_rt_ren = beq|bne`.
- Datapath:
  - `pd_pc_8 = if_pc+8`, 32-bit wrap.
  - `pd_pc`, `pd_inst` and `pd_addr_error` pass through.
- Gshare:
  - `idx = if_pc[GHR_LEN+1:2] ^ spec_ghr`.
  - PHT holds 2-bit saturating counters. `pd_bp_take = b & pht[idx][1]`.
  - `pd_gshare_wen = b`. `pd_gshare_windex = idx`.
- Targets:
  - b: `pc+4 + (sext(imm16)<<2)`.
  - j_dir: `{pc4[31:28], inst[25:0], 2'b00}`.
  - j_r: BTB entry `bidx = if_pc[BTB_LEN+1:2]`. Hit = valid and tag equals `if_pc[31:BTB_LEN+2]`.
- Redirect: `pd_redirect = v & ~stall & (pd_bp_take | j_dir | (j_r & hit))`. `pd_redirect_pc` is the selected target. Fetch sequences the delay slot.
- BTB tags out: `pd_btb_wen = j_r`, `pd_btb_windex = bidx`, `pd_btb_wtarget` = hit target, else 0.
- `pd_bd`: a register set to `pd_branch` of the last valid, non-stalled instruction.
- Spec GHR:
  - Shifts `{spec_ghr[GHR_LEN-2:0], pd_bp_take}` on `v & b & ~stall`.
  - arch GHR shifts in `ex_taken` on `ex_gshare_wen`.
- PHT update on `ex_gshare_wen`: increment at `ex_gshare_windex` if `ex_taken`, else decrement; saturate at 00 and 11.
- BTB write on `ex_btb_wen`: entry at `ex_btb_windex` gets valid=1, tag from `ex_btb_wpc`, target.

## Timing
- Predecode, lookup and redirect are combinational in the same cycle. The PHT and BTB use asynchronous read.
- Table updates are visible the next cycle. A same-cycle read and write to one entry returns the old value.
- Reset:
  - `spec_ghr`, `arch_ghr` = 0.
  - Every PHT counter = 01.
  - BTB valid bits = 0.
  - `pd_bd` = 0.
- Priority is reset > `ex_bp_fail` > `refresh` > `stall`:
  - `ex_bp_fail`: `spec_ghr <= {arch_ghr[GHR_LEN-2:0], ex_taken}` when `ex_gshare_wen`, else `arch_ghr`. `pd_bd <= 0`.
  - `refresh`: `spec_ghr <= arch_ghr`, `pd_bd <= 0`.
  - `stall`: `spec_ghr` and `pd_bd` hold. EX-side table and arch GHR updates still proceed.
- A mid-update `resetn` low discards the update.

## Structure
- `` `GHR_LEN ``, `` `GHR_BITS ``, `` `BTB_LEN ``, `` `BTB_BITS `` and the opcode/funct constants live in `head.vh`.
- One sub-module, `gshare_pht`: the counter array with async read and saturating sync update.
- The BTB and the decode logic are inline.

## Test plan
- After reset, `if_pc=0xBFC00000`, inst `0x10220004` (beq) → `pd_b`, `op_beq`, `rs_ren`, `rt_ren` = 1; `pd_pc_8=0xBFC00008`; `bp_take=0`; `pd_redirect=0`.
- Two `ex_gshare_wen` with `ex_taken=1` at that index, then the same beq → `pd_redirect=1`, `pd_redirect_pc=0xBFC00014`, `spec_ghr=0x01`.
- `if_pc=0xBFC00100`, inst `0x0BF00080` (j) → redirect to `0xBFC00200`. The next valid instruction has `pd_bd=1`.
- `jr $31` (`0x03E00008`) at `0x80000040` → miss, `pd_btb_wen=1`, no redirect. Then `ex_btb_wen` with target `0x80001000`, and the same pc → redirect to `0x80001000`.
- `spec_ghr=0x07`, `arch_ghr=0x01`, then `ex_bp_fail` with `ex_gshare_wen=1`, `ex_taken=0` → `spec_ghr=0x02`, `pd_bd=0`.
- `stall=1` for 3 cycles with a valid beq → `spec_ghr` and `pd_bd` unchanged, `pd_redirect=0`. `refresh` → `pd_bd=0`.

Source files
------------

// File: rtl/pd_predecode_pkg.sv
// Shared constants and branch-class decode for the predecode stage.
package pd_predecode_pkg;

  localparam int unsigned GHR_LEN_DEF = 8;
  localparam int unsigned BTB_LEN_DEF = 6;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  // Weakly not-taken initial counter value.
  localparam logic [1:0] PHT_INIT   = 2'b01;

  typedef struct packed {
    logic j_dir;
    logic j_r;
    logic bltz;
    logic bgez;
    logic beq;
    logic bne;
    logic blez;
    logic bgtz;
  } br_dec_t;

  function automatic br_dec_t br_decode(input logic [5:0] op,
                                        input logic [4:0] rt,
                                        input logic [5:0] fn);
    br_dec_t d;
    d       = '0;
    d.j_dir = (op == OP_J) || (op == OP_JAL);
    d.j_r   = (op == OP_SPECIAL) && ((fn == FN_JR) || (fn == FN_JALR));
    d.bltz  = (op == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BLTZAL));
    d.bgez  = (op == OP_REGIMM) && ((rt == RT_BGEZ) || (rt == RT_BGEZAL));
    d.beq   = (op == OP_BEQ);
    d.bne   = (op == OP_BNE);
    d.blez  = (op == OP_BLEZ);
    d.bgtz  = (op == OP_BGTZ);
    return d;
  endfunction

endpackage

// File: rtl/pd_predecode_gshare_pht.sv
// Gshare pattern history table: 2-bit saturating counters, async read,
// synchronous saturating update from branch resolution.
module gshare_pht
  import pd_predecode_pkg::*;
#(
  parameter int unsigned IDX_W = GHR_LEN_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [1:0]       o_rdata,
  input  logic             i_wen,
  input  logic [IDX_W-1:0] i_widx,
  input  logic             i_taken
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0] r_cnt [DEPTH];
  logic [1:0] w_cur;

  assign o_rdata = r_cnt[i_ridx];
  assign w_cur   = r_cnt[i_widx];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= PHT_INIT;
      end
    end else if (i_wen) begin
      if (i_taken && (w_cur != 2'b11)) begin
        r_cnt[i_widx] <= w_cur + 2'd1;
      end else if (!i_taken && (w_cur != 2'b00)) begin
        r_cnt[i_widx] <= w_cur - 2'd1;
      end
    end
  end

endmodule

// File: rtl/pd_predecode.sv
// Predecode stage: branch classification, gshare direction prediction,
// BTB lookup for register jumps, and same-cycle fetch redirect.
module pd_predecode
  import pd_predecode_pkg::*;
#(
  parameter int unsigned GHR_LEN = GHR_LEN_DEF,
  parameter int unsigned BTB_LEN = BTB_LEN_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               stall,
  input  logic               refresh,
  input  logic               if_valid,
  input  logic               if_addr_error,
  input  logic [31:0]        if_pc,
  input  logic [31:0]        if_inst,
  input  logic               ex_gshare_wen,
  input  logic [GHR_LEN-1:0] ex_gshare_windex,
  input  logic               ex_taken,
  input  logic               ex_btb_wen,
  input  logic [BTB_LEN-1:0] ex_btb_windex,
  input  logic [31:0]        ex_btb_wpc,
  input  logic [31:0]        ex_btb_wtarget,
  input  logic               ex_bp_fail,
  output logic               pd_addr_error,
  output logic [31:0]        pd_pc,
  output logic [31:0]        pd_pc_8,
  output logic [31:0]        pd_inst,
  output logic               pd_bd,
  output logic               pd_branch,
  output logic               pd_b,
  output logic               pd_j_dir,
  output logic               pd_j_r,
  output logic               pd_b_rs_ren,
  output logic               pd_b_rt_ren,
  output logic               pd_btb_wen,
  output logic [BTB_LEN-1:0] pd_btb_windex,
  output logic [31:0]        pd_btb_wtarget,
  output logic               pd_gshare_wen,
  output logic [GHR_LEN-1:0] pd_gshare_windex,
  output logic               pd_bp_take,
  output logic               pd_op_bltz,
  output logic               pd_op_bgez,
  output logic               pd_op_beq,
  output logic               pd_op_bne,
  output logic               pd_op_blez,
  output logic               pd_op_bgtz,
  output logic               pd_redirect,
  output logic [31:0]        pd_redirect_pc
);

  localparam int unsigned TAG_W     = 32 - BTB_LEN - 2;
  localparam int unsigned BTB_DEPTH = 1 << BTB_LEN;

  logic [GHR_LEN-1:0]   r_spec_ghr;
  logic [GHR_LEN-1:0]   r_arch_ghr;
  logic                 r_bd;
  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag    [BTB_DEPTH];
  logic [31:0]          r_btb_target [BTB_DEPTH];

  logic                 w_v;
  br_dec_t              w_dec;
  logic                 w_b;
  logic                 w_branch;
  logic [31:0]          w_pc_4;
  logic [31:0]          w_b_target;
  logic [31:0]          w_j_target;
  logic [GHR_LEN-1:0]   w_pht_idx;
  logic [1:0]           w_pht_cnt;
  logic                 w_bp_take;
  logic [BTB_LEN-1:0]   w_bidx;
  logic                 w_btb_hit;
  logic [31:0]          w_btb_target;
  logic                 w_unused_wpc;

  assign w_unused_wpc = ^ex_btb_wpc[BTB_LEN+1:0];

  // Every flag is qualified by a valid, error-free fetch.
  assign w_v      = if_valid & ~if_addr_error;
  assign w_dec    = w_v ? br_decode(if_inst[31:26], if_inst[20:16], if_inst[5:0])
                        : br_dec_t'('0);
  assign w_b      = w_dec.bltz | w_dec.bgez | w_dec.beq |
                    w_dec.bne  | w_dec.blez | w_dec.bgtz;
  assign w_branch = w_b | w_dec.j_dir | w_dec.j_r;

  assign w_pc_4     = if_pc + 32'd4;
  assign w_b_target = w_pc_4 + {{14{if_inst[15]}}, if_inst[15:0], 2'b00};
  assign w_j_target = {w_pc_4[31:28], if_inst[25:0], 2'b00};

  assign w_pht_idx = if_pc[GHR_LEN+1:2] ^ r_spec_ghr;
  assign w_bp_take = w_b & w_pht_cnt[1];

  gshare_pht #(
    .IDX_W (GHR_LEN)
  ) u_pht (
    .clk     (clk),
    .resetn  (resetn),
    .i_ridx  (w_pht_idx),
    .o_rdata (w_pht_cnt),
    .i_wen   (ex_gshare_wen),
    .i_widx  (ex_gshare_windex),
    .i_taken (ex_taken)
  );

  assign w_bidx       = if_pc[BTB_LEN+1:2];
  assign w_btb_target = r_btb_target[w_bidx];
  assign w_btb_hit    = r_btb_valid[w_bidx] &&
                        (r_btb_tag[w_bidx] == if_pc[31:BTB_LEN+2]);

  assign pd_addr_error    = if_addr_error;
  assign pd_pc            = if_pc;
  assign pd_pc_8          = if_pc + 32'd8;
  assign pd_inst          = if_inst;
  assign pd_bd            = r_bd;
  assign pd_branch        = w_branch;
  assign pd_b             = w_b;
  assign pd_j_dir         = w_dec.j_dir;
  assign pd_j_r           = w_dec.j_r;
  assign pd_b_rs_ren      = w_b | w_dec.j_r;
  assign pd_b_rt_ren      = w_dec.beq | w_dec.bne;
  assign pd_op_bltz       = w_dec.bltz;
  assign pd_op_bgez       = w_dec.bgez;
  assign pd_op_beq        = w_dec.beq;
  assign pd_op_bne        = w_dec.bne;
  assign pd_op_blez       = w_dec.blez;
  assign pd_op_bgtz       = w_dec.bgtz;
  assign pd_gshare_wen    = w_b;
  assign pd_gshare_windex = w_pht_idx;
  assign pd_bp_take       = w_bp_take;
  assign pd_btb_wen       = w_dec.j_r;
  assign pd_btb_windex    = w_bidx;
  assign pd_btb_wtarget   = (w_dec.j_r && w_btb_hit) ? w_btb_target : 32'd0;

  assign pd_redirect = w_v & ~stall &
                       (w_bp_take | w_dec.j_dir | (w_dec.j_r & w_btb_hit));

  // Branch classes are mutually exclusive, so the target mux has no priority.
  always_comb begin
    pd_redirect_pc = pd_pc_8;
    if (w_dec.j_dir) begin
      pd_redirect_pc = w_j_target;
    end else if (w_dec.j_r) begin
      pd_redirect_pc = w_btb_target;
    end else if (w_b) begin
      pd_redirect_pc = w_b_target;
    end
  end

  // History and delay-slot tracking; misprediction beats exception flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_spec_ghr <= '0;
      r_arch_ghr <= '0;
      r_bd       <= 1'b0;
    end else begin
      if (ex_gshare_wen) begin
        r_arch_ghr <= {r_arch_ghr[GHR_LEN-2:0], ex_taken};
      end
      if (ex_bp_fail) begin
        r_spec_ghr <= ex_gshare_wen ? {r_arch_ghr[GHR_LEN-2:0], ex_taken}
                                    : r_arch_ghr;
        r_bd       <= 1'b0;
      end else if (refresh) begin
        r_spec_ghr <= r_arch_ghr;
        r_bd       <= 1'b0;
      end else if (!stall) begin
        if (w_v && w_b) begin
          r_spec_ghr <= {r_spec_ghr[GHR_LEN-2:0], w_bp_take};
        end
        if (w_v) begin
          r_bd <= w_branch;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_btb_valid <= '0;
    end else if (ex_btb_wen) begin
      r_btb_valid[ex_btb_windex] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; entries are qualified by r_btb_valid.
  always_ff @(posedge clk) begin
    if (resetn && ex_btb_wen) begin
      r_btb_tag[ex_btb_windex]    <= ex_btb_wpc[31:BTB_LEN+2];
      r_btb_target[ex_btb_windex] <= ex_btb_wtarget;
    end
  end

endmodule
